// File: rtl/fat32_volume_mounter_if.sv
// fat32_volume_mounter_if
//   SD block-read port between the FAT32 volume mounter (master) and the
//   SD controller (slave).
//   sd_ready        SD controller initialised and idle
//   blk_req         one-cycle read request
//   blk_addr        sector LBA, stable until blk_done
//   blk_byte        read data byte
//   blk_byte_valid  blk_byte valid this cycle
//   blk_done        end of the current block
interface fat32_volume_mounter_if;
    logic        sd_ready;
    logic        blk_req;
    logic [31:0] blk_addr;
    logic [7:0]  blk_byte;
    logic        blk_byte_valid;
    logic        blk_done;

    modport master (
        input  sd_ready,
        output blk_req,
        output blk_addr,
        input  blk_byte,
        input  blk_byte_valid,
        input  blk_done
    );

    modport slave (
        output sd_ready,
        input  blk_req,
        input  blk_addr,
        output blk_byte,
        output blk_byte_valid,
        output blk_done
    );
endinterface

// File: rtl/fat32_volume_mounter.sv
// fat32_volume_mounter
//   Reads the MBR (LBA 0) and the FAT32 volume ID of partition PART_INDEX,
//   validates both sectors and publishes the filesystem geometry.
//   Optional watchdog: define FAT32_MOUNT_TIMEOUT_EN to enable err_code 7.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   mount_start          single-cycle start pulse (ignored while busy)
//   bus                  SD block-read port (master side)
//   busy                 mount in progress
//   mounted              geometry outputs valid
//   error, err_code      mount failed: 1 MBR_SIG 2 PART_TYPE 3 VID_SIG 4 BPS
//                        5 NUMFATS 6 BYTECNT 7 TIMEOUT
//   fat_begin_lba        part_lba + reserved_sectors
//   cluster_begin_lba    fat_begin_lba + num_fats*sectors_per_fat
//   sectors_per_cluster  BPB byte 13
//   root_cluster         BPB bytes 44..47
module fat32_volume_mounter #(
    parameter int PART_INDEX     = 0,
    parameter int NUM_FATS_MAX   = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mount_start,
    fat32_volume_mounter_if.master        bus,
    output logic                          busy,
    output logic                          mounted,
    output logic                          error,
    output logic [2:0]                    err_code,
    output logic [31:0]                   fat_begin_lba,
    output logic [31:0]                   cluster_begin_lba,
    output logic [7:0]                    sectors_per_cluster,
    output logic [31:0]                   root_cluster
);
    localparam logic [9:0] E_TYPE   = 10'(446 + 16*PART_INDEX + 4);
    localparam logic [9:0] E_LBA_LO = 10'(446 + 16*PART_INDEX + 8);
    localparam logic [9:0] E_LBA_HI = 10'(446 + 16*PART_INDEX + 11);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_SD, S_RD_MBR, S_RD_VID, S_CALC, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q;
    logic        vid_phase_q;            // second request targets the volume ID
    logic [7:0]  ptype_q, spc_q, nfats_q, b510_q, b511_q;
    logic [15:0] bps_q, rsvd_q;
    logic [31:0] part_lba_q, spf_q, root_q;

    logic        byte_ok, issue, start, sig_ok;
    logic [9:0]  cnt_nx;
    logic [7:0]  eff511;
    logic [2:0]  fail_code;
    logic [31:0] prod;

    assign busy    = (state_q == S_WAIT_SD) || (state_q == S_RD_MBR) ||
                     (state_q == S_RD_VID)  || (state_q == S_CALC);
    assign byte_ok = bus.blk_byte_valid && ((state_q == S_RD_MBR) || (state_q == S_RD_VID));
    // Count and last byte include a byte landing in the same cycle as blk_done.
    assign cnt_nx  = cnt_q + {9'd0, byte_ok};
    assign eff511  = (byte_ok && cnt_q == 10'd511) ? bus.blk_byte : b511_q;
    assign sig_ok  = (b510_q == 8'h55) && (eff511 == 8'hAA);

    // num_fats * sectors_per_fat as a shift-add, modulo 2^32
    always_comb begin
        prod = 32'd0;
        for (int i = 0; i < 8; i++)
            if (nfats_q[i]) prod = prod + (spf_q << i);
    end

`ifdef FAT32_MOUNT_TIMEOUT_EN
    logic [31:0] wd_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         wd_q <= 32'd0;
        else if (!busy || issue || byte_ok) wd_q <= 32'd0;
        else                                wd_q <= wd_q + 32'd1;
    end
`endif

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        start     = 1'b0;
        fail_code = 3'd0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR:
                if (mount_start) begin
                    start   = 1'b1;
                    state_d = S_WAIT_SD;
                end
            S_WAIT_SD:
                if (bus.sd_ready) begin
                    issue   = 1'b1;
                    state_d = vid_phase_q ? S_RD_VID : S_RD_MBR;
                end
            S_RD_MBR:
                if (byte_ok && cnt_q == 10'd512)           fail_code = 3'd6;
                else if (bus.blk_done) begin
                    if (cnt_nx != 10'd512)                 fail_code = 3'd6;
                    else if (!sig_ok)                      fail_code = 3'd1;
                    else if (ptype_q != 8'h0B && ptype_q != 8'h0C) fail_code = 3'd2;
                    else                                   state_d = S_WAIT_SD;
                end
            S_RD_VID:
                if (byte_ok && cnt_q == 10'd512)           fail_code = 3'd6;
                else if (bus.blk_done) begin
                    if (cnt_nx != 10'd512)                 fail_code = 3'd6;
                    else if (!sig_ok)                      fail_code = 3'd3;
                    else if (bps_q != 16'd512)             fail_code = 3'd4;
                    else if (nfats_q == 8'd0 || nfats_q > 8'(NUM_FATS_MAX)) fail_code = 3'd5;
                    else                                   state_d = S_CALC;
                end
            S_CALC:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
`ifdef FAT32_MOUNT_TIMEOUT_EN
        if (busy && fail_code == 3'd0 && wd_q >= 32'(TIMEOUT_CYCLES - 1)) begin
            fail_code = 3'd7;
            issue     = 1'b0;
        end
`endif
        if (fail_code != 3'd0) state_d = S_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= S_IDLE;
            cnt_q               <= 10'd0;
            vid_phase_q         <= 1'b0;
            ptype_q             <= 8'd0;
            spc_q               <= 8'd0;
            nfats_q             <= 8'd0;
            b510_q              <= 8'd0;
            b511_q              <= 8'd0;
            bps_q               <= 16'd0;
            rsvd_q              <= 16'd0;
            part_lba_q          <= 32'd0;
            spf_q               <= 32'd0;
            root_q              <= 32'd0;
            bus.blk_req         <= 1'b0;
            bus.blk_addr        <= 32'd0;
            mounted             <= 1'b0;
            error               <= 1'b0;
            err_code            <= 3'd0;
            fat_begin_lba       <= 32'd0;
            cluster_begin_lba   <= 32'd0;
            sectors_per_cluster <= 8'd0;
            root_cluster        <= 32'd0;
        end else begin
            state_q     <= state_d;
            bus.blk_req <= issue;
            if (start) begin
                vid_phase_q         <= 1'b0;
                bus.blk_addr        <= 32'd0;
                mounted             <= 1'b0;
                error               <= 1'b0;
                err_code            <= 3'd0;
                fat_begin_lba       <= 32'd0;
                cluster_begin_lba   <= 32'd0;
                sectors_per_cluster <= 8'd0;
                root_cluster        <= 32'd0;
            end
            if (issue) begin
                cnt_q  <= 10'd0;
                b510_q <= 8'd0;
                b511_q <= 8'd0;
            end else if (byte_ok) begin
                cnt_q <= cnt_q + 10'd1;
                if (cnt_q == 10'd510) b510_q <= bus.blk_byte;
                if (cnt_q == 10'd511) b511_q <= bus.blk_byte;
                // Little-endian fields are shifted in from the top.
                if (state_q == S_RD_MBR) begin
                    if (cnt_q == E_TYPE) ptype_q <= bus.blk_byte;
                    if (cnt_q >= E_LBA_LO && cnt_q <= E_LBA_HI)
                        part_lba_q <= {bus.blk_byte, part_lba_q[31:8]};
                end else begin
                    if (cnt_q == 10'd11 || cnt_q == 10'd12) bps_q  <= {bus.blk_byte, bps_q[15:8]};
                    if (cnt_q == 10'd13)                    spc_q  <= bus.blk_byte;
                    if (cnt_q == 10'd14 || cnt_q == 10'd15) rsvd_q <= {bus.blk_byte, rsvd_q[15:8]};
                    if (cnt_q == 10'd16)                    nfats_q <= bus.blk_byte;
                    if (cnt_q >= 10'd36 && cnt_q <= 10'd39) spf_q  <= {bus.blk_byte, spf_q[31:8]};
                    if (cnt_q >= 10'd44 && cnt_q <= 10'd47) root_q <= {bus.blk_byte, root_q[31:8]};
                end
            end
            if (state_q == S_RD_MBR && state_d == S_WAIT_SD) begin
                vid_phase_q  <= 1'b1;
                bus.blk_addr <= part_lba_q;
            end
            if (fail_code != 3'd0) begin
                error    <= 1'b1;
                err_code <= fail_code;
            end
            if (state_q == S_CALC) begin
                fat_begin_lba       <= part_lba_q + {16'd0, rsvd_q};
                cluster_begin_lba   <= part_lba_q + {16'd0, rsvd_q} + prod;
                sectors_per_cluster <= spc_q;
                root_cluster        <= root_q;
                mounted             <= 1'b1;
            end
        end
    end
endmodule
